expand_offset_unit: RTL and testbench

- Read-side counterpart of the compress offset unit, used by the rv32v vector lane for expand-style (viota / masked-gather) operations.
- Walks the element range two elements per cycle.
- For each active mask bit, issues a read offset into the packed source: the count of set mask bits below that element.
- Reports the destination element index per lane.
- Started by the vector control unit; stalled by the lane pipeline; aborted by a done input.

---
 rtl/rv32v_types_pkg.sv | 21 ++
 rtl/expand_offset_unit_if.sv | 30 +++
 rtl/mask_pair_select.sv | 28 ++
 rtl/expand_offset_unit.sv | 112 +++++++++++
 tb/tb_expand_offset_unit.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/rv32v_types_pkg.sv
// Shared vector-lane types: element/offset widths, pair index type and the
// expand offset walker state encoding.
package rv32v_types_pkg;
    localparam int VLMAX    = 64;
    localparam int OFFSET_W = 7;
    localparam int IDX_W    = $clog2(VLMAX);
    localparam int PAIR_W   = (VLMAX > 2) ? $clog2(VLMAX / 2) : 1;

    typedef logic [OFFSET_W-1:0] offset_t;
    typedef logic [PAIR_W-1:0]   pair_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } expand_state_t;

    function automatic offset_t clamp_vl(offset_t v);
        return (v > offset_t'(VLMAX)) ? offset_t'(VLMAX) : v;
    endfunction
endpackage

// File: rtl/expand_offset_unit_if.sv
// Control/lane bundle between the vector control unit, the lane pipeline and
// the expand offset walker.
interface expand_offset_unit_if;
    import rv32v_types_pkg::*;

    logic             ena;
    logic             done;
    logic             stall;
    offset_t          vl;
    logic [VLMAX-1:0] mask;
    logic             busy;
    logic [1:0]       ren;
    offset_t          roffset0;
    offset_t          roffset1;
    offset_t          eidx0;
    offset_t          eidx1;
    logic             last;
    logic             fin;
    offset_t          active_cnt;

    modport expand_offset_unit (
        input  ena, done, stall, vl, mask,
        output busy, ren, roffset0, roffset1, eidx0, eidx1, last, fin, active_cnt
    );

    modport master (
        output ena, done, stall, vl, mask,
        input  busy, ren, roffset0, roffset1, eidx0, eidx1, last, fin, active_cnt
    );
endinterface

// File: rtl/mask_pair_select.sv
// Picks the mask bits for element pair k (elements 2k and 2k+1) and flags
// which of the two elements fall inside the vector length. Shared with compress.
module mask_pair_select
    import rv32v_types_pkg::*;
(
    input  logic [VLMAX-1:0] mask_i,
    input  pair_t            k_i,
    input  offset_t          vl_i,
    output offset_t          e0_o,
    output offset_t          e1_o,
    output logic             v0_o,
    output logic             v1_o,
    output logic             m0_o,
    output logic             m1_o
);
    logic [IDX_W-1:0] idx0;
    logic [IDX_W-1:0] idx1;

    assign idx0 = {k_i, 1'b0};
    assign idx1 = {k_i, 1'b1};

    assign e0_o = offset_t'(idx0);
    assign e1_o = offset_t'(idx1);
    assign v0_o = (e0_o < vl_i);
    assign v1_o = (e1_o < vl_i);
    assign m0_o = mask_i[idx0];
    assign m1_o = mask_i[idx1];
endmodule

// File: rtl/expand_offset_unit.sv
// Expand offset walker: steps the element range two at a time and, for each
// active mask bit, emits the packed-source offset (count of set bits below it).
module expand_offset_unit
    import rv32v_types_pkg::*;
(
    input  logic CLK,
    input  logic nRST,
    expand_offset_unit_if.expand_offset_unit bus
);
    expand_state_t state_q, state_d;
    pair_t         k_q, k_d;
    offset_t       cnt_q, cnt_d;
    offset_t       vl_q, vl_d;

    offset_t e0, e1;
    logic    v0, v1, m0, m1;
    logic    ren0, ren1, is_last;
    offset_t vl_lat;

    mask_pair_select u_sel (
        .mask_i (bus.mask),
        .k_i    (k_q),
        .vl_i   (vl_q),
        .e0_o   (e0),
        .e1_o   (e1),
        .v0_o   (v0),
        .v1_o   (v1),
        .m0_o   (m0),
        .m1_o   (m1)
    );

    assign ren0    = v0 & m0;
    assign ren1    = v1 & m1;
    // vl_q is never zero while in RUN, so vl_q-1 cannot underflow there.
    assign is_last = (e1 >= (vl_q - offset_t'(1)));
    assign vl_lat  = clamp_vl(bus.vl);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            k_q     <= '0;
            cnt_q   <= '0;
            vl_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            vl_q    <= vl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        vl_d    = vl_q;
        if (bus.done) begin
            state_d = IDLE;
            k_d     = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.ena && !bus.stall) begin
                        k_d     = '0;
                        cnt_d   = '0;
                        vl_d    = vl_lat;
                        state_d = (vl_lat != '0) ? RUN : FINISH;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        cnt_d = cnt_q + offset_t'(ren0) + offset_t'(ren1);
                        k_d   = k_q + 1'b1;
                        if (is_last) state_d = FINISH;
                    end
                end
                FINISH:  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy       = 1'b0;
        bus.ren        = 2'b00;
        bus.roffset0   = '0;
        bus.roffset1   = '0;
        bus.eidx0      = '0;
        bus.eidx1      = '0;
        bus.last       = 1'b0;
        bus.fin        = 1'b0;
        bus.active_cnt = '0;
        case (state_q)
            RUN: begin
                bus.busy     = 1'b1;
                bus.ren      = {ren1, ren0};
                bus.roffset0 = cnt_q;
                bus.roffset1 = cnt_q + offset_t'(ren0);
                bus.eidx0    = e0;
                bus.eidx1    = e1;
                bus.last     = is_last;
            end
            FINISH: begin
                bus.busy       = 1'b1;
                bus.fin        = 1'b1;
                bus.active_cnt = cnt_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_expand_offset_unit.sv
// Directed bench for expand_offset_unit: a per-pair table for one run, a
// table of whole-run vectors, and hand sequences for stall/abort/reset.
module tb_expand_offset_unit;
    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    expand_offset_unit_if bus ();

    expand_offset_unit dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0] ren;
        logic [6:0] r0, r1, e0, e1;
        logic       last;
    } pair_vec_t;

    typedef struct {
        logic [6:0]  vl;
        logic [63:0] mask;
        int          npairs;
        logic [6:0]  active;
        logic [1:0]  lren;
        logic [6:0]  lr0, lr1, le0;
    } run_vec_t;

    pair_vec_t pv [4];
    run_vec_t  rv [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".busy"}, 64'(bus.busy), 0);
        chk({nm, ".ren"}, 64'(bus.ren), 0);
        chk({nm, ".roff0"}, 64'(bus.roffset0), 0);
        chk({nm, ".roff1"}, 64'(bus.roffset1), 0);
        chk({nm, ".eidx0"}, 64'(bus.eidx0), 0);
        chk({nm, ".eidx1"}, 64'(bus.eidx1), 0);
        chk({nm, ".last"}, 64'(bus.last), 0);
        chk({nm, ".fin"}, 64'(bus.fin), 0);
        chk({nm, ".active"}, 64'(bus.active_cnt), 0);
    endtask

    task automatic start(input logic [6:0] vl, input logic [63:0] mask);
        bus.vl   = vl;
        bus.mask = mask;
        bus.ena  = 1'b1;
        @(negedge CLK);
        bus.ena  = 1'b0;
    endtask

    initial begin
        pv[0] = '{ren: 2'b10, r0: 7'd0, r1: 7'd0, e0: 7'd0, e1: 7'd1, last: 1'b0};
        pv[1] = '{ren: 2'b01, r0: 7'd1, r1: 7'd2, e0: 7'd2, e1: 7'd3, last: 1'b0};
        pv[2] = '{ren: 2'b11, r0: 7'd2, r1: 7'd3, e0: 7'd4, e1: 7'd5, last: 1'b0};
        pv[3] = '{ren: 2'b10, r0: 7'd4, r1: 7'd4, e0: 7'd6, e1: 7'd7, last: 1'b1};

        rv[0] = '{vl: 7'd8,   mask: 64'hB6,                  npairs: 4,  active: 7'd5,
                  lren: 2'b10, lr0: 7'd4,  lr1: 7'd4,  le0: 7'd6};
        rv[1] = '{vl: 7'd5,   mask: 64'hFFFF_FFFF_FFFF_FFFF, npairs: 3,  active: 7'd5,
                  lren: 2'b01, lr0: 7'd4,  lr1: 7'd5,  le0: 7'd4};
        rv[2] = '{vl: 7'd0,   mask: 64'hFFFF_FFFF_FFFF_FFFF, npairs: 0,  active: 7'd0,
                  lren: 2'b00, lr0: 7'd0,  lr1: 7'd0,  le0: 7'd0};
        rv[3] = '{vl: 7'd64,  mask: 64'hFFFF_FFFF_FFFF_FFFF, npairs: 32, active: 7'd64,
                  lren: 2'b11, lr0: 7'd62, lr1: 7'd63, le0: 7'd62};
        rv[4] = '{vl: 7'd100, mask: 64'h5555_5555_5555_5555, npairs: 32, active: 7'd32,
                  lren: 2'b01, lr0: 7'd31, lr1: 7'd32, le0: 7'd62};
        rv[5] = '{vl: 7'd3,   mask: 64'h4,                   npairs: 2,  active: 7'd1,
                  lren: 2'b01, lr0: 7'd0,  lr1: 7'd1,  le0: 7'd2};
        rv[6] = '{vl: 7'd1,   mask: 64'h1,                   npairs: 1,  active: 7'd1,
                  lren: 2'b01, lr0: 7'd0,  lr1: 7'd1,  le0: 7'd0};

        bus.ena   = 1'b0;
        bus.done  = 1'b0;
        bus.stall = 1'b0;
        bus.vl    = '0;
        bus.mask  = '0;

        repeat (2) @(negedge CLK);
        chk_all_zero("reset");
        nRST = 1'b1;
        @(negedge CLK);
        chk("idle.busy", 64'(bus.busy), 0);

        // Per-pair walk of vl=8, mask=0xB6
        start(7'd8, 64'hB6);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("b6[%0d].ren", i), 64'(bus.ren), 64'(pv[i].ren));
            chk($sformatf("b6[%0d].roff0", i), 64'(bus.roffset0), 64'(pv[i].r0));
            chk($sformatf("b6[%0d].roff1", i), 64'(bus.roffset1), 64'(pv[i].r1));
            chk($sformatf("b6[%0d].eidx0", i), 64'(bus.eidx0), 64'(pv[i].e0));
            chk($sformatf("b6[%0d].eidx1", i), 64'(bus.eidx1), 64'(pv[i].e1));
            chk($sformatf("b6[%0d].last", i), 64'(bus.last), 64'(pv[i].last));
            chk($sformatf("b6[%0d].busy", i), 64'(bus.busy), 1);
            chk($sformatf("b6[%0d].fin", i), 64'(bus.fin), 0);
            @(negedge CLK);
        end
        chk("b6.fin", 64'(bus.fin), 1);
        chk("b6.active", 64'(bus.active_cnt), 5);
        chk("b6.fin_ren", 64'(bus.ren), 0);
        @(negedge CLK);
        chk("b6.post_busy", 64'(bus.busy), 0);

        // Whole-run vectors
        for (int v = 0; v < 7; v++) begin
            start(rv[v].vl, rv[v].mask);
            for (int p = 0; p < rv[v].npairs; p++) begin
                chk($sformatf("run%0d[%0d].eidx0", v, p), 64'(bus.eidx0), 64'(2 * p));
                chk($sformatf("run%0d[%0d].busy", v, p), 64'(bus.busy), 1);
                chk($sformatf("run%0d[%0d].fin", v, p), 64'(bus.fin), 0);
                chk($sformatf("run%0d[%0d].last", v, p), 64'(bus.last),
                    64'(p == rv[v].npairs - 1));
                if (p == rv[v].npairs - 1) begin
                    chk($sformatf("run%0d.lren", v), 64'(bus.ren), 64'(rv[v].lren));
                    chk($sformatf("run%0d.lroff0", v), 64'(bus.roffset0), 64'(rv[v].lr0));
                    chk($sformatf("run%0d.lroff1", v), 64'(bus.roffset1), 64'(rv[v].lr1));
                    chk($sformatf("run%0d.leidx0", v), 64'(bus.eidx0), 64'(rv[v].le0));
                end
                @(negedge CLK);
            end
            chk($sformatf("run%0d.fin", v), 64'(bus.fin), 1);
            chk($sformatf("run%0d.active", v), 64'(bus.active_cnt), 64'(rv[v].active));
            chk($sformatf("run%0d.fin_busy", v), 64'(bus.busy), 1);
            chk($sformatf("run%0d.fin_ren", v), 64'(bus.ren), 0);
            chk($sformatf("run%0d.fin_last", v), 64'(bus.last), 0);
            chk($sformatf("run%0d.fin_eidx0", v), 64'(bus.eidx0), 0);
            @(negedge CLK);
            chk($sformatf("run%0d.post_busy", v), 64'(bus.busy), 0);
            chk($sformatf("run%0d.post_fin", v), 64'(bus.fin), 0);
        end

        // Stall for 3 cycles on the second pair
        start(7'd8, 64'hFF);
        chk("stall.p0_roff1", 64'(bus.roffset1), 1);
        @(negedge CLK);
        bus.stall = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.stall = 1'b0;
            chk($sformatf("stall[%0d].eidx0", c), 64'(bus.eidx0), 2);
            chk($sformatf("stall[%0d].roff0", c), 64'(bus.roffset0), 2);
            chk($sformatf("stall[%0d].roff1", c), 64'(bus.roffset1), 3);
            chk($sformatf("stall[%0d].ren", c), 64'(bus.ren), 2'b11);
            @(negedge CLK);
        end
        chk("stall.p2_eidx0", 64'(bus.eidx0), 4);
        @(negedge CLK);
        chk("stall.p3_last", 64'(bus.last), 1);
        @(negedge CLK);
        chk("stall.fin", 64'(bus.fin), 1);
        chk("stall.active", 64'(bus.active_cnt), 8);
        @(negedge CLK);

        // ena while busy is ignored
        start(7'd4, 64'hF);
        bus.vl  = 7'd2;
        bus.ena = 1'b1;
        @(negedge CLK);
        bus.ena = 1'b0;
        chk("ign.eidx0", 64'(bus.eidx0), 2);
        chk("ign.last", 64'(bus.last), 1);
        @(negedge CLK);
        chk("ign.fin", 64'(bus.fin), 1);
        chk("ign.active", 64'(bus.active_cnt), 4);
        @(negedge CLK);
        chk("ign.post_busy", 64'(bus.busy), 0);

        // done aborts mid-run and overrides stall/ena
        start(7'd8, 64'hFF);
        @(negedge CLK);
        chk("abort.p1_eidx0", 64'(bus.eidx0), 2);
        bus.done  = 1'b1;
        bus.stall = 1'b1;
        bus.ena   = 1'b1;
        @(negedge CLK);
        bus.done  = 1'b0;
        bus.stall = 1'b0;
        bus.ena   = 1'b0;
        chk("abort.busy", 64'(bus.busy), 0);
        chk("abort.fin", 64'(bus.fin), 0);
        chk("abort.ren", 64'(bus.ren), 0);
        start(7'd2, 64'h2);
        chk("abort.re_ren", 64'(bus.ren), 2'b10);
        chk("abort.re_roff1", 64'(bus.roffset1), 0);
        chk("abort.re_last", 64'(bus.last), 1);
        @(negedge CLK);
        chk("abort.re_fin", 64'(bus.fin), 1);
        chk("abort.re_active", 64'(bus.active_cnt), 1);
        @(negedge CLK);

        // Asynchronous reset mid-run
        start(7'd8, 64'hFF);
        @(negedge CLK);
        chk("rst.pre_busy", 64'(bus.busy), 1);
        nRST = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("rst.post_busy", 64'(bus.busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
